csr_unit: RTL and testbench

Machine-mode CSR file and trap controller for a single-hart RV32 core.
- Holds mstatus, mie, mtvec, mscratch, mepc, mcause, mtval, plus read-only misa, mhartid and mvendorid.
- Records exceptions and returns the redirect PC for trap entry and for mret.
- Sits beside the execute/writeback stage and drives the front-end PC mux.

---
 rtl/csr_pkg.sv | 53 +++++
 rtl/csr_cycle_counter.sv | 37 +++
 rtl/csr_unit.sv | 137 +++++++++++++
 tb/tb_csr_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR addresses, mstatus field positions and exception codes.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package csr_pkg;

  // Machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;

  // mstatus bit positions
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  // Only MSIE/MTIE/MEIE exist in mie for a machine-only hart
  localparam logic [31:0] MIE_MASK = 32'h0000_0888;

  // Synchronous exception codes carried in mcause[4:0]
  typedef enum logic [4:0] {
    INSN_MISALIGNED  = 5'd0,
    INSN_ACCESS      = 5'd1,
    ILLEGAL          = 5'd2,
    BREAKPOINT       = 5'd3,
    LOAD_MISALIGNED  = 5'd4,
    LOAD_ACCESS      = 5'd5,
    STORE_MISALIGNED = 5'd6,
    STORE_ACCESS     = 5'd7,
    ECALL_U          = 5'd8,
    ECALL_S          = 5'd9,
    ECALL_M          = 5'd11
  } exc_code_e;

  // Assemble the architectural mstatus view; MPP is hardwired to machine mode
  function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
    logic [31:0] v;
    v = 32'h0000_1800;
    v[MSTATUS_MIE]  = mie;
    v[MSTATUS_MPIE] = mpie;
    return v;
  endfunction

endpackage

// File: rtl/csr_cycle_counter.sv
// csr_cycle_counter: free-running 64-bit mcycle with per-half write override.
// Latency: writes land on the next edge; count_o is the registered value.
// Backpressure: none; a write in a cycle replaces that cycle's increment.
module csr_cycle_counter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] count_o
);

  logic [63:0] count_q;
  logic [63:0] count_d;

  // Next count: a software write to either half wins over the increment
  always_comb begin
    count_d = count_q + 64'd1;
    if (wr_lo_i) begin
      count_d = {count_q[63:32], wdata_i};
    end else if (wr_hi_i) begin
      count_d = {wdata_i, count_q[31:0]};
    end
  end

  // Counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= 64'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file and trap/mret redirect for a single RV32 hart.
// Latency: reads and redirects are combinational; CSR updates land on the next edge.
// Backpressure: none; exception > mret > CSR write, losers are dropped.
// Optional: define CSR_COUNTERS_EN to build the 64-bit mcycle/cycle counter.
module csr_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] HART_ID     = 32'h0,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        csr_we_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  input  logic        exception_i,
  input  logic [31:0] exception_pc_i,
  input  logic [31:0] exception_cause_i,
  input  logic        mret_i,
  output logic [31:0] trap_pc_o,
  output logic        trap_taken_o,
  output logic        mie_o
);

  logic        mstatus_mie_q;
  logic        mstatus_mpie_q;
  logic [31:0] mie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;

  logic        csr_wr;
  logic [31:0] mtvec_base;

  // A write only commits when no trap or mret is claiming the cycle
  assign csr_wr     = csr_we_i & ~exception_i & ~mret_i;
  assign mtvec_base = {mtvec_q[31:2], 2'b00};

`ifdef CSR_COUNTERS_EN
  logic [63:0] cycle_cnt;

  csr_cycle_counter u_cycle_counter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_lo_i (csr_wr && (csr_addr_i == CSR_MCYCLE)),
    .wr_hi_i (csr_wr && (csr_addr_i == CSR_MCYCLEH)),
    .wdata_i (csr_wdata_i),
    .count_o (cycle_cnt)
  );
`endif

  // Combinational CSR read mux; unimplemented addresses return zero
  always_comb begin
    csr_rdata_o = 32'h0;
    case (csr_addr_i)
      CSR_MSTATUS:   csr_rdata_o = mstatus_pack(mstatus_mie_q, mstatus_mpie_q);
      CSR_MISA:      csr_rdata_o = MISA_VAL;
      CSR_MIE:       csr_rdata_o = mie_q;
      CSR_MTVEC:     csr_rdata_o = mtvec_q;
      CSR_MSCRATCH:  csr_rdata_o = mscratch_q;
      CSR_MEPC:      csr_rdata_o = mepc_q;
      CSR_MCAUSE:    csr_rdata_o = mcause_q;
      CSR_MTVAL:     csr_rdata_o = mtval_q;
      CSR_MHARTID:   csr_rdata_o = HART_ID;
      CSR_MVENDORID: csr_rdata_o = 32'h0;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:    csr_rdata_o = cycle_cnt[31:0];
      CSR_MCYCLEH:   csr_rdata_o = cycle_cnt[63:32];
      CSR_CYCLE:     csr_rdata_o = cycle_cnt[31:0];
      CSR_CYCLEH:    csr_rdata_o = cycle_cnt[63:32];
`endif
      default:       csr_rdata_o = 32'h0;
    endcase
  end

  // Front-end redirect: trap vector on exception, saved mepc on mret
  always_comb begin
    trap_taken_o = 1'b0;
    trap_pc_o    = 32'h0;
    if (!rst_i) begin
      if (exception_i) begin
        trap_taken_o = 1'b1;
        if (mtvec_q[0] && exception_cause_i[31]) begin
          trap_pc_o = mtvec_base + {25'b0, exception_cause_i[4:0], 2'b00};
        end else begin
          trap_pc_o = mtvec_base;
        end
      end else if (mret_i) begin
        trap_taken_o = 1'b1;
        trap_pc_o    = mepc_q;
      end
    end
  end

  // CSR state: trap entry and mret update mstatus/mepc/mcause, else software writes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= 32'h0;
      mtvec_q        <= {MTVEC_RESET[31:2], 1'b0, MTVEC_RESET[0]};
      mscratch_q     <= 32'h0;
      mepc_q         <= 32'h0;
      mcause_q       <= 32'h0;
      mtval_q        <= 32'h0;
    end else if (exception_i) begin
      mepc_q         <= {exception_pc_i[31:1], 1'b0};
      mcause_q       <= exception_cause_i;
      mstatus_mpie_q <= mstatus_mie_q;
      mstatus_mie_q  <= 1'b0;
    end else if (mret_i) begin
      mstatus_mie_q  <= mstatus_mpie_q;
      mstatus_mpie_q <= 1'b1;
    end else if (csr_wr) begin
      case (csr_addr_i)
        CSR_MSTATUS: begin
          mstatus_mie_q  <= csr_wdata_i[MSTATUS_MIE];
          mstatus_mpie_q <= csr_wdata_i[MSTATUS_MPIE];
        end
        CSR_MIE:      mie_q      <= csr_wdata_i & MIE_MASK;
        CSR_MTVEC:    mtvec_q    <= {csr_wdata_i[31:2], 1'b0, csr_wdata_i[0]};
        CSR_MSCRATCH: mscratch_q <= csr_wdata_i;
        CSR_MEPC:     mepc_q     <= {csr_wdata_i[31:1], 1'b0};
        CSR_MCAUSE:   mcause_q   <= csr_wdata_i;
        CSR_MTVAL:    mtval_q    <= csr_wdata_i;
        default:      ;
      endcase
    end
  end

  assign mie_o = mstatus_mie_q;

endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: scoreboard bench for csr_unit (reads, traps, mret, priority).
module tb_csr_unit;
  import csr_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        csr_we_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_rdata_o;
  logic        exception_i;
  logic [31:0] exception_pc_i;
  logic [31:0] exception_cause_i;
  logic        mret_i;
  logic [31:0] trap_pc_o;
  logic        trap_taken_o;
  logic        mie_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  csr_unit #(
    .HART_ID     (32'h0),
    .MTVEC_RESET (32'h0000_0000),
    .MISA_VAL    (32'h4000_0100)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .csr_we_i          (csr_we_i),
    .csr_addr_i        (csr_addr_i),
    .csr_wdata_i       (csr_wdata_i),
    .csr_rdata_o       (csr_rdata_o),
    .exception_i       (exception_i),
    .exception_pc_i    (exception_pc_i),
    .exception_cause_i (exception_cause_i),
    .mret_i            (mret_i),
    .trap_pc_o         (trap_pc_o),
    .trap_taken_o      (trap_taken_o),
    .mie_o             (mie_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expectation recorded with the stimulus
  task automatic sb_push(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  // Scoreboard: compare the oldest expectation against what the DUT shows now
  task automatic sb_pop(input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'h1, 32'h0);
    end else begin
      check(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk_i);
    csr_we_i    = 1'b1;
    csr_addr_i  = a;
    csr_wdata_i = d;
    @(negedge clk_i);
    csr_we_i    = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    @(negedge clk_i);
    csr_addr_i = a;
    sb_push(tag, exp);
    #2;
    sb_pop(csr_rdata_o);
  endtask

  // One-cycle pulse of trap/mret/write inputs with redirect checked mid-cycle
  task automatic pulse(input string tag, input logic e, input logic m, input logic w,
                       input logic [11:0] a, input logic [31:0] d,
                       input logic [31:0] pc, input logic [31:0] cause,
                       input logic exp_taken, input logic [31:0] exp_pc);
    @(negedge clk_i);
    exception_i       = e;
    mret_i            = m;
    csr_we_i          = w;
    csr_addr_i        = a;
    csr_wdata_i       = d;
    exception_pc_i    = pc;
    exception_cause_i = cause;
    sb_push({tag, "_taken"}, {31'b0, exp_taken});
    sb_push({tag, "_pc"}, exp_pc);
    #2;
    sb_pop({31'b0, trap_taken_o});
    sb_pop(trap_pc_o);
    @(negedge clk_i);
    exception_i = 1'b0;
    mret_i      = 1'b0;
    csr_we_i    = 1'b0;
  endtask

  initial begin
    rst_i             = 1'b1;
    csr_we_i          = 1'b0;
    csr_addr_i        = 12'h0;
    csr_wdata_i       = 32'h0;
    exception_i       = 1'b1;
    exception_pc_i    = 32'h444;
    exception_cause_i = 32'd2;
    mret_i            = 1'b0;

    // 1. Reset: outputs held quiet even with an exception request present
    repeat (2) @(negedge clk_i);
    check("rst_trap_taken", {31'b0, trap_taken_o}, 32'h0);
    check("rst_trap_pc", trap_pc_o, 32'h0);
    check("rst_mie_o", {31'b0, mie_o}, 32'h0);
    exception_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    read_chk("rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
    read_chk("rst_mtvec", CSR_MTVEC, 32'h0);
    read_chk("rst_mepc", CSR_MEPC, 32'h0);
    read_chk("misa", CSR_MISA, 32'h4000_0100);
    read_chk("mhartid", CSR_MHARTID, 32'h0);
    read_chk("unimpl", 12'h7C0, 32'h0);
    check("rst_idle_taken", {31'b0, trap_taken_o}, 32'h0);

    // 2. Write/read and hardwired bits
    csr_write(CSR_MTVEC, 32'h100);
    read_chk("mtvec_100", CSR_MTVEC, 32'h100);
    csr_write(CSR_MTVEC, 32'h103);
    read_chk("mtvec_bit1", CSR_MTVEC, 32'h101);
    csr_write(CSR_MIE, 32'hFFFF_FFFF);
    read_chk("mie_mask", CSR_MIE, 32'h0000_0888);
    csr_write(CSR_MSTATUS, 32'hFFFF_FFFF);
    read_chk("mstatus_mask", CSR_MSTATUS, 32'h0000_1888);
    check("mie_o_set", {31'b0, mie_o}, 32'h1);
    csr_write(CSR_MSTATUS, 32'h0);
    read_chk("mstatus_clr", CSR_MSTATUS, 32'h0000_1800);
    csr_write(CSR_MEPC, 32'h123);
    read_chk("mepc_bit0", CSR_MEPC, 32'h122);
    csr_write(CSR_MISA, 32'h0);
    read_chk("misa_ro", CSR_MISA, 32'h4000_0100);
    csr_write(CSR_MTVAL, 32'hCAFE_F00D);
    read_chk("mtval", CSR_MTVAL, 32'hCAFE_F00D);

    // 3. Exception with MIE=1
    csr_write(CSR_MTVEC, 32'h100);
    csr_write(CSR_MSTATUS, 32'h8);
    pulse("exc", 1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 32'h200, 32'(ECALL_M), 1'b1, 32'h100);
    read_chk("exc_mepc", CSR_MEPC, 32'h200);
    read_chk("exc_mcause", CSR_MCAUSE, 32'd11);
    read_chk("exc_mstatus", CSR_MSTATUS, 32'h0000_1880);
    check("exc_mie_o", {31'b0, mie_o}, 32'h0);

    // 4. mret
    pulse("mret", 1'b0, 1'b1, 1'b0, 12'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h200);
    check("mret_mie_o", {31'b0, mie_o}, 32'h1);
    read_chk("mret_mstatus", CSR_MSTATUS, 32'h0000_1888);

    // Idle cycle drives nothing
    @(negedge clk_i);
    check("idle_taken", {31'b0, trap_taken_o}, 32'h0);
    check("idle_pc", trap_pc_o, 32'h0);

    // 5. Vectored mode: interrupts offset, synchronous causes use base
    csr_write(CSR_MTVEC, 32'h101);
    pulse("vec_irq", 1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 32'h300, 32'h8000_0007, 1'b1, 32'h11C);
    read_chk("vec_mcause", CSR_MCAUSE, 32'h8000_0007);
    pulse("vec_sync", 1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 32'h305, 32'(ILLEGAL), 1'b1, 32'h100);
    read_chk("vec_mepc_bit0", CSR_MEPC, 32'h304);

    // 6. Priority: exception beats mret beats write
    csr_write(CSR_MSCRATCH, 32'h55);
    pulse("prio", 1'b1, 1'b1, 1'b1, CSR_MSCRATCH, 32'hDEAD, 32'h400, 32'(BREAKPOINT),
          1'b1, 32'h100);
    read_chk("prio_mscratch", CSR_MSCRATCH, 32'h55);
    read_chk("prio_mepc", CSR_MEPC, 32'h400);
    read_chk("prio_mcause", CSR_MCAUSE, 32'd3);
    read_chk("prio_mstatus", CSR_MSTATUS, 32'h0000_1800);

    // mret beats a write too
    pulse("mret_wr", 1'b0, 1'b1, 1'b1, CSR_MSCRATCH, 32'hBEEF, 32'h0, 32'h0, 1'b1, 32'h400);
    read_chk("mret_wr_mscratch", CSR_MSCRATCH, 32'h55);

`ifdef CSR_COUNTERS_EN
    // Counter: write overrides increment, then counts on every edge
    csr_write(CSR_MCYCLE, 32'd100);
    read_chk("mcycle", CSR_MCYCLE, 32'd101);
    read_chk("cycle", CSR_CYCLE, 32'd102);
    csr_write(CSR_MCYCLEH, 32'd5);
    read_chk("mcycleh", CSR_MCYCLEH, 32'd5);
    read_chk("cycleh", CSR_CYCLEH, 32'd5);
`else
    // Counter addresses are inert without the feature
    csr_write(CSR_MCYCLE, 32'd100);
    read_chk("mcycle_off", CSR_MCYCLE, 32'h0);
    read_chk("cycle_off", CSR_CYCLE, 32'h0);
    read_chk("cycleh_off", CSR_CYCLEH, 32'h0);
`endif

    if (exp_q.size() != 0) begin
      check("sb_leftover", exp_q.size(), 32'h0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the run can never hang
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
